alu_seq_ctrl: RTL and testbench



---
 rtl/alu_seq_ctrl_pkg.sv | 22 ++
 rtl/alu_seq_ctrl_div_iter_64.sv | 62 ++++++
 rtl/alu_seq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU sequencing controller: op codes, FSM states,
// divider iteration count and the most-negative 64-bit value.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_DIV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  localparam int unsigned DIV_ITERS = 64;
  localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;

  typedef enum logic [2:0] {IDLE, EXEC, MWAIT, DIVL, RESP} state_t;

  // Magnitude of a two's-complement value; |INT64_MIN| = 2^63 fits unsigned.
  function automatic logic [63:0] abs64(input logic [63:0] v);
    return v[63] ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_div_iter_64.sv
// Unsigned restoring divider: one quotient bit per cycle, DIV_ITERS cycles.
// start loads the operands; done pulses for one cycle once the quotient is final.
module div_iter_64
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic [63:0] quotient,
  output logic        done
);

  logic [63:0] rem;
  logic [63:0] quo;
  logic [63:0] dvs;
  logic [5:0]  cnt;
  logic        busy;
  logic [64:0] shifted;
  logic [64:0] diff;
  logic        fits;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    shifted = {rem, quo[63]};
    diff    = shifted - {1'b0, dvs};
    fits    = ~diff[64];
  end

  // Operand load on start, then one shift/subtract step per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem  <= '0;
        quo  <= dividend;
        dvs  <= divisor;
        cnt  <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        rem <= fits ? diff[63:0] : shifted[63:0];
        quo <= {quo[62:0], fits};
        cnt <= cnt + 6'd1;
        if (cnt == 6'(DIV_ITERS - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller in front of the shared 64-bit ALU. Accepts one op at a
// time, holds ALU inputs stable, runs DIV in its own iterative divider and
// returns result/flags/tag on a valid/ready response channel.
// Optional: define ALU_SEQ_PERF_EN to add perf_ops/perf_busy counters.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_ctrl,
  input  logic [63:0]      req_a,
  input  logic [63:0]      req_b,
  input  logic             req_cin,
  input  logic [TAG_W-1:0] req_tag,
  output logic [63:0]      alu_a,
  output logic [63:0]      alu_b,
  output logic             alu_cin,
  output logic [3:0]       alu_ctrl,
  input  logic [127:0]     alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [127:0]     rsp_result,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_divzero,
  output logic [TAG_W-1:0] rsp_tag
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_busy
`endif
);

  localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic             div_bzero;
  logic             div_ovf;
  logic             div_start;
  logic             div_done;
  logic             mul_last;
  logic [CNT_W-1:0] mul_cnt;
  logic [63:0]      mag_a;
  logic [63:0]      mag_b;
  logic [63:0]      div_q;
  logic [63:0]      q_signed;

  assign div_bzero = (req_b == '0);
  assign div_ovf   = (req_a == INT64_MIN) && (req_b == '1);
  assign mul_last  = (mul_cnt == MUL_LAST);
  assign mag_a     = abs64(req_a);
  assign mag_b     = abs64(req_b);
  // alu_a/alu_b still hold the original signed operands while dividing.
  assign q_signed  = (alu_a[63] ^ alu_b[63]) ? (~div_q + 64'd1) : div_q;

  div_iter_64 u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quotient (div_q),
    .done     (div_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    div_start = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_ctrl == OP_MUL) begin
            state_nxt = MWAIT;
          end else if (req_ctrl == OP_DIV) begin
            if (div_bzero || div_ovf) begin
              state_nxt = RESP;
            end else begin
              state_nxt = DIVL;
              div_start = 1'b1;
            end
          end else begin
            state_nxt = EXEC;
          end
        end
      end
      EXEC:    state_nxt = RESP;
      MWAIT:   if (mul_last) state_nxt = RESP;
      DIVL:    if (div_done) state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept and result capture per execution path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_cin      <= 1'b0;
      alu_ctrl     <= '0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_divzero  <= 1'b0;
      rsp_tag      <= '0;
      mul_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_a    <= req_a;
            alu_b    <= req_b;
            alu_cin  <= req_cin;
            alu_ctrl <= req_ctrl;
            rsp_tag  <= req_tag;
            mul_cnt  <= '0;
            if (req_ctrl == OP_DIV && div_bzero) begin
              rsp_result   <= '1;
              rsp_zero     <= 1'b0;
              rsp_overflow <= 1'b0;
              rsp_divzero  <= 1'b1;
            end else if (req_ctrl == OP_DIV && div_ovf) begin
              rsp_result   <= {{64{1'b1}}, INT64_MIN};
              rsp_zero     <= 1'b0;
              rsp_overflow <= 1'b1;
              rsp_divzero  <= 1'b0;
            end
          end
        end
        EXEC: begin
          rsp_result   <= alu_result;
          rsp_zero     <= alu_zero;
          rsp_overflow <= alu_overflow && (alu_ctrl == OP_ADD || alu_ctrl == OP_SUB);
          rsp_divzero  <= 1'b0;
        end
        MWAIT: begin
          if (mul_last) begin
            rsp_result   <= alu_result;
            rsp_zero     <= (alu_result == '0);
            rsp_overflow <= 1'b0;
            rsp_divzero  <= 1'b0;
          end else begin
            mul_cnt <= mul_cnt + 1'b1;
          end
        end
        DIVL: begin
          if (div_done) begin
            rsp_result   <= {{64{q_signed[63]}}, q_signed};
            rsp_zero     <= (q_signed == '0);
            rsp_overflow <= 1'b0;
            rsp_divzero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_EN
  // Response and busy-cycle counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops  <= '0;
      perf_busy <= '0;
    end else begin
      if (rsp_valid && rsp_ready) perf_ops <= perf_ops + 32'd1;
      if (state != IDLE)          perf_busy <= perf_busy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: behavioural ALU stand-in, arithmetic
// reference model, directed cases, randomized ops, backpressure and abort.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  localparam int unsigned TAG_W   = 4;
  localparam int unsigned MUL_LAT = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [3:0]       req_ctrl = '0;
  logic [63:0]      req_a = '0;
  logic [63:0]      req_b = '0;
  logic             req_cin = 1'b0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [63:0]      alu_a;
  logic [63:0]      alu_b;
  logic             alu_cin;
  logic [3:0]       alu_ctrl;
  logic [127:0]     alu_result;
  logic             alu_zero;
  logic             alu_overflow;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [127:0]     rsp_result;
  logic             rsp_zero;
  logic             rsp_overflow;
  logic             rsp_divzero;
  logic [TAG_W-1:0] rsp_tag;
`ifdef ALU_SEQ_PERF_EN
  logic [31:0]      perf_ops;
  logic [31:0]      perf_busy;
`endif

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_ctrl     (req_ctrl),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_cin      (req_cin),
    .req_tag      (req_tag),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_cin      (alu_cin),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_divzero  (rsp_divzero),
    .rsp_tag      (rsp_tag)
`ifdef ALU_SEQ_PERF_EN
    ,
    .perf_ops     (perf_ops),
    .perf_busy    (perf_busy)
`endif
  );

  // Stand-in for the shared ALU. Its divide output is deliberately junk so a
  // controller that used it would be caught.
  logic [63:0]         alu_s64;
  logic signed [127:0] alu_p;
  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    alu_s64      = '0;
    alu_p        = '0;
    case (alu_ctrl)
      OP_AND: alu_result = {64'd0, alu_a & alu_b};
      OP_ADD: begin
        alu_s64      = alu_a + alu_b + {63'd0, alu_cin};
        alu_result   = {{64{alu_s64[63]}}, alu_s64};
        alu_overflow = (alu_a[63] == alu_b[63]) && (alu_s64[63] != alu_a[63]);
      end
      OP_SUB: begin
        alu_s64      = alu_a - alu_b;
        alu_result   = {{64{alu_s64[63]}}, alu_s64};
        alu_overflow = (alu_a[63] != alu_b[63]) && (alu_s64[63] != alu_a[63]);
      end
      OP_MUL: begin
        alu_p        = $signed({{64{alu_a[63]}}, alu_a}) * $signed({{64{alu_b[63]}}, alu_b});
        alu_result   = alu_p;
        alu_overflow = (alu_p[127:63] != '0) && (alu_p[127:63] != '1);
      end
      OP_SLT: alu_result = {127'd0, $signed(alu_a) < $signed(alu_b)};
      OP_DIV: begin
        alu_result   = 128'hDEAD_BEEF_0000_0000_0000_0000_DEAD_BEEF;
        alu_overflow = 1'b1;
      end
      default: ;
    endcase
    alu_zero = (alu_result == '0);
  end

  // Reference response: plain signed arithmetic on 128-bit / longint values.
  function automatic void model(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                                input logic cin, output logic [127:0] r, output logic ov,
                                output logic dz, output int lat);
    longint sa, sb, q;
    logic signed [127:0] wa, wb, w, wl;
    logic signed [63:0] lo;
    sa = a; sb = b; wa = sa; wb = sb;
    r = '0; ov = 1'b0; dz = 1'b0; lat = 2;
    case (c)
      OP_ADD, OP_SUB: begin
        w  = (c == OP_ADD) ? wa + wb + 128'(cin) : wa - wb;
        lo = w[63:0]; wl = lo;
        ov = (w != wl);
        r  = wl;
      end
      OP_MUL: begin
        w = wa * wb; r = w; lat = 1 + int'(MUL_LAT);
      end
      OP_DIV: begin
        lat = 1;
        if (b == '0) begin
          r = '1; dz = 1'b1;
        end else if (a == INT64_MIN && b == '1) begin
          lo = INT64_MIN; wl = lo; r = wl; ov = 1'b1;
        end else begin
          q = sa / sb; wl = q; r = wl; lat = 66;
        end
      end
      OP_AND:  r = {64'd0, a & b};
      OP_SLT:  r = (sa < sb) ? 128'd1 : 128'd0;
      default: r = '0;
    endcase
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // One request/response transaction with optional response backpressure.
  task automatic run_op(input string nm, input logic [3:0] c, input logic [63:0] a,
                        input logic [63:0] b, input logic cin, input logic [TAG_W-1:0] tag,
                        input int stall);
    logic [127:0] er, snap_r;
    logic eo, ed, snap_z, snap_o, snap_d, hold_ok, stall_ok;
    logic [TAG_W-1:0] snap_t;
    int elat, cyc;
    model(c, a, b, cin, er, eo, ed, elat);
    @(negedge clk);
    req_ctrl = c; req_a = a; req_b = b; req_cin = cin; req_tag = tag; req_valid = 1'b1;
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL %s req_ready_idle: got %b expected 1", nm, req_ready);
    else n_pass++;
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = rand64(); req_b = rand64(); req_ctrl = 4'($urandom);
    req_cin = 1'($urandom); req_tag = TAG_W'($urandom);
    @(negedge clk);
    cyc = 1; hold_ok = 1'b1;
    while (rsp_valid !== 1'b1 && cyc < 200) begin
      if (alu_a !== a || alu_b !== b || alu_ctrl !== c || alu_cin !== cin || req_ready !== 1'b0)
        hold_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (alu_a !== a || alu_b !== b || alu_ctrl !== c || alu_cin !== cin || req_ready !== 1'b0)
      hold_ok = 1'b0;
    n_total++;
    if (cyc != elat) $display("FAIL %s latency: got %0d expected %0d", nm, cyc, elat);
    else n_pass++;
    n_total++;
    if (!hold_ok) $display("FAIL %s alu_hold: got unstable expected a=%h b=%h ctrl=%h", nm, a, b, c);
    else n_pass++;
    n_total++;
    if (rsp_result !== er) $display("FAIL %s result: got %h expected %h", nm, rsp_result, er);
    else n_pass++;
    n_total++;
    if (rsp_zero !== (er == '0)) $display("FAIL %s zero: got %b expected %b", nm, rsp_zero, er == '0);
    else n_pass++;
    n_total++;
    if (rsp_overflow !== eo) $display("FAIL %s overflow: got %b expected %b", nm, rsp_overflow, eo);
    else n_pass++;
    n_total++;
    if (rsp_divzero !== ed) $display("FAIL %s divzero: got %b expected %b", nm, rsp_divzero, ed);
    else n_pass++;
    n_total++;
    if (rsp_tag !== tag) $display("FAIL %s tag: got %h expected %h", nm, rsp_tag, tag);
    else n_pass++;
    if (stall > 0) begin
      snap_r = rsp_result; snap_z = rsp_zero; snap_o = rsp_overflow; snap_d = rsp_divzero;
      snap_t = rsp_tag; stall_ok = 1'b1;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== snap_r || rsp_zero !== snap_z ||
            rsp_overflow !== snap_o || rsp_divzero !== snap_d || rsp_tag !== snap_t)
          stall_ok = 1'b0;
      end
      n_total++;
      if (!stall_ok) $display("FAIL %s backpressure_hold: got change expected stable for %0d cycles", nm, stall);
      else n_pass++;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    n_total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL %s return_idle: got valid=%b ready=%b expected valid=0 ready=1", nm, rsp_valid, req_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    #12;
    n_total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL reset handshake: got ready=%b valid=%b expected ready=1 valid=0", req_ready, rsp_valid);
    else n_pass++;
    n_total++;
    if ({alu_a, alu_b, alu_cin, alu_ctrl} !== '0)
      $display("FAIL reset alu_outputs: got a=%h b=%h cin=%b ctrl=%h expected 0", alu_a, alu_b, alu_cin, alu_ctrl);
    else n_pass++;
    n_total++;
    if ({rsp_result, rsp_zero, rsp_overflow, rsp_divzero, rsp_tag} !== '0)
      $display("FAIL reset rsp_outputs: got r=%h z=%b o=%b d=%b t=%h expected 0",
               rsp_result, rsp_zero, rsp_overflow, rsp_divzero, rsp_tag);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op("add_5_7", OP_ADD, 64'd5, 64'd7, 1'b0, 4'd3, 0);
    run_op("sub_min_1", OP_SUB, INT64_MIN, 64'd1, 1'b0, 4'd4, 0);
    run_op("mul_m3_4", OP_MUL, -64'sd3, 64'd4, 1'b0, 4'd5, 0);
    run_op("div_m100_7", OP_DIV, -64'sd100, 64'd7, 1'b0, 4'd6, 0);
    run_op("div_by_zero", OP_DIV, 64'd9, 64'd0, 1'b0, 4'd7, 0);
    run_op("div_min_m1", OP_DIV, INT64_MIN, '1, 1'b0, 4'd8, 0);
    run_op("slt_neg", OP_SLT, -64'sd2, 64'd1, 1'b0, 4'd9, 0);
    run_op("unlisted", 4'b1111, 64'd12, 64'd34, 1'b1, 4'd10, 0);
  endtask

  task automatic test_backpressure();
    run_op("and_stall5", OP_AND, 64'hF0F0_1234_5678_00FF, 64'h0FF0_FFFF_0000_FFFF, 1'b0, 4'd11, 5);
  endtask

  task automatic test_abort();
    logic quiet;
    @(negedge clk);
    req_ctrl = OP_DIV; req_a = -64'sd1000; req_b = 64'd3; req_cin = 1'b0; req_tag = 4'd12;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_a !== '0 || alu_ctrl !== '0 || rsp_tag !== '0)
      $display("FAIL abort async_reset: got ready=%b valid=%b a=%h ctrl=%h tag=%h expected 1,0,0,0,0",
               req_ready, rsp_valid, alu_a, alu_ctrl, rsp_tag);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (80) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) quiet = 1'b0;
    end
    n_total++;
    if (!quiet) $display("FAIL abort no_response: got response or busy expected idle");
    else n_pass++;
    run_op("add_after_abort", OP_ADD, 64'd100, -64'sd1, 1'b1, 4'd13, 0);
  endtask

  task automatic test_random();
    logic [3:0] ops [8];
    logic [63:0] corner [5];
    logic [63:0] a, b;
    ops[0] = OP_AND; ops[1] = OP_DIV; ops[2] = OP_ADD; ops[3] = OP_MUL;
    ops[4] = OP_SUB; ops[5] = OP_SLT; ops[6] = 4'b0101; ops[7] = 4'b1100;
    corner[0] = '0; corner[1] = '1; corner[2] = INT64_MIN; corner[3] = 64'd1;
    corner[4] = 64'h7FFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 30; i++) begin
      a = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 4)] : rand64();
      b = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 4)] : rand64();
      if ($urandom_range(0, 2) == 0) b = 64'(int'($urandom_range(0, 40)) - 20);
      run_op($sformatf("rand%0d", i), ops[$urandom_range(0, 7)], a, b, 1'($urandom),
             TAG_W'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
